// File: rtl/pulse_counter_mc.sv
// Multi-channel programmable pulse counter: each channel counts rising edges on
// its pulse input, strobes hit on a target match, then stops or auto-reloads.
module pulse_counter_mc #(
  parameter int CNT_W = 8,
  parameter int CH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       clr,
  input  logic [CH-1:0]       pulse_in,
  input  logic [CH-1:0]       reload,
  input  logic [CH*CNT_W-1:0] target,
  output logic [CH*CNT_W-1:0] count,
  output logic [CH-1:0]       hit,
  output logic [CH-1:0]       done_n,
  output logic [CH-1:0]       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q [CH];
  state_e           state_d [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] cnt_d   [CH];
  logic [CNT_W-1:0] nxt     [CH];
  logic [CNT_W-1:0] tgt     [CH];
  logic [CH-1:0]    hit_q, hit_d;
  logic [CH-1:0]    done_n_q, done_n_d;
  logic [CH-1:0]    ovf_q, ovf_d;
  logic [CH-1:0]    prev_q, prev_d;
  logic [CH-1:0]    edge_det;

  always_comb begin
    hit_d    = '0;
    done_n_d = done_n_q;
    ovf_d    = ovf_q;
    prev_d   = pulse_in;
    edge_det = pulse_in & ~prev_q;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tgt[i]     = target[i*CNT_W +: CNT_W];
      nxt[i]     = cnt_q[i] + 1'b1;
      if (clr[i]) begin
        cnt_d[i]    = '0;
        ovf_d[i]    = 1'b0;
        done_n_d[i] = 1'b1;
        state_d[i]  = en[i] ? COUNT : IDLE;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (en[i]) begin
              state_d[i] = COUNT;
              cnt_d[i]   = '0;
            end
          end
          COUNT: begin
            if (!en[i]) begin
              state_d[i] = IDLE;
            end else if (edge_det[i]) begin
              // A zero target disables matching so the channel free-runs
              if ((tgt[i] != '0) && (nxt[i] == tgt[i])) begin
                hit_d[i] = 1'b1;
                if (reload[i]) begin
                  cnt_d[i] = '0;
                end else begin
                  cnt_d[i]    = tgt[i];
                  done_n_d[i] = 1'b0;
                  state_d[i]  = DONE;
                end
              end else begin
                cnt_d[i] = nxt[i];
                if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
              end
            end
          end
          DONE: begin
            if (!en[i]) begin
              state_d[i]  = IDLE;
              done_n_d[i] = 1'b1;
            end
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      hit_q    <= '0;
      done_n_q <= '1;
      ovf_q    <= '0;
      prev_q   <= '1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hit_q    <= hit_d;
      done_n_q <= done_n_d;
      ovf_q    <= ovf_d;
      prev_q   <= prev_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_count
    assign count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign hit    = hit_q;
  assign done_n = done_n_q;
  assign ovf    = ovf_q;

endmodule
